dbp_bht_updater: RTL
====================

// Module: dbp_bht_updater
// PURPOSE
//  Update stage for the dynamic branch predictor BHT, driving BHT channel 2 (add2/rdata2/wen2/wdata2).
//  Accepts resolved-branch records from execute through a valid/ready handshake and queues them in a small FIFO.
//  Applies each record as a read-modify-write of one 2-bit saturating counter packed in a 32-bit BHT word.
//  Sustained throughput is one update per 2 cycles; the FIFO absorbs bursts. The fetch-side read port (channel 1) is untouched.
// PARAMETERS
//  AWIDTH      10  BHT word-address width; must match the BHT instance
//  DWIDTH      32  BHT word width; fixed at 16 x 2-bit counters
//  FIFO_DEPTH  4   resolved-branch queue entries, power of 2, >= 2
// PORTS
//  clk         in   1       clock; all logic is posedge
//  reset       in   1       synchronous, active-high
//  upd_valid   in   1       execute presents a resolved branch
//  upd_ready   out  1       queue can accept; a transfer occurs when upd_valid & upd_ready
//  upd_pc      in   32      PC of the resolved branch
//  upd_taken   in   1       actual branch outcome
//  bht_add2    out  AWIDTH  BHT channel-2 word address
//  bht_rdata2  in   DWIDTH  BHT channel-2 registered read data, valid 1 cycle after the address
//  bht_wen2    out  1       BHT channel-2 write enable
//  bht_wdata2  out  DWIDTH  BHT channel-2 write data
//  busy        out  1       FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Indexing
//   - word address = upd_pc[AWIDTH+5:6]
//   - counter select s = upd_pc[5:2]; the counter is field [2s+1:2s]
//   - upd_pc[1:0] is ignored
//  Reset values: FIFO empty, FSM IDLE, upd_ready=1, bht_wen2=0, bht_add2=0, bht_wdata2=0, busy=0.
//  Reset mid-operation
//   - queued and in-flight updates are dropped; no write is issued in the reset cycle
//   - upd_ready=1 from the first cycle after reset deasserts
//  FIFO
//   - upd_ready = !full, combinational from the FIFO count
//   - push on upd_valid & upd_ready; stores {word addr, s, taken}
//   - pop when the FSM leaves IDLE or WR toward RD
//   - simultaneous push and pop keeps the count unchanged
//   - a push into an empty FIFO is poppable on the next cycle (no bypass)
//  FSM (state encoding from the shared package)
//   - IDLE: bht_wen2=0. If the FIFO is non-empty: pop into a head register, bht_add2 <= head addr, go to RD.
//   - RD: bht_add2 held; the BHT registers ram[addr]. Go to WR.
//   - WR: bht_rdata2 is valid. bht_wen2=1, bht_add2 = head addr, bht_wdata2 = bht_rdata2 with field s replaced by cnt'.
//     If the FIFO is non-empty: pop the next record, go to RD. Otherwise go to IDLE.
//  Output timing: bht_wen2 and bht_wdata2 are combinational in WR from the registered head and bht_rdata2; bht_add2 is registered.
//  Counter arithmetic, with cnt = rdata2 field s
//   - taken: cnt' = (cnt==2'b11) ? 2'b11 : cnt+1
//   - not taken: cnt' = (cnt==2'b00) ? 2'b00 : cnt-1
//   - all other 15 fields pass through unchanged
//  Hazards
//   - a back-to-back update to the same word needs no forwarding: its RD follows the previous WR edge, so it reads the written value
//  Ordering: updates are applied in strict arrival order; there is no coalescing.
// STRUCTURE
//  Package dbp_pkg
//   - CNT_W=2, CNT_PER_WORD=16
//   - state encoding IDLE/RD/WR
//   - update-record struct {addr, sel, taken}
//   - function sat_cnt(cnt, taken)
//  Sub-module dbp_upd_fifo: synchronous FIFO, FIFO_DEPTH x record, ports push/pop/full/empty, reset clears the pointers.
//  Top level: the FSM plus the field-merge logic.
// TESTING (bench includes a DBP_BHT model with word 0x0000_0000 at reset)
//  1. Single taken update, pc=0x0000_0044 (addr=1, s=1)
//     -> add2=1 for RD+WR, wen2 pulses 1 cycle, wdata2=0x0000_0004.
//  2. Four taken updates to the same pc, back-to-back
//     -> field goes 1,2,3,3 (saturates); final word 0x0000_000C; 8 cycles from first pop.
//  3. Not-taken on a zero field -> write of an unchanged word, field stays 0; taken on another field leaves its neighbours intact.
//  4. Burst of 6 valid cycles with FIFO_DEPTH=4
//     -> upd_ready drops once full, no record is lost or duplicated, writes appear in order.
//  5. Reset asserted during RD with 3 records queued
//     -> no wen2, busy=0 and upd_ready=1 the cycle after reset deasserts.
//  6. Random 2000-update stream vs a reference model of the 2-bit counters -> final BHT contents match exactly.

Source files
------------

// File: rtl/dbp_pkg.sv
// Shared types and helpers for the dynamic branch predictor BHT update path.
package dbp_pkg;

  localparam int unsigned CNT_W        = 2;
  localparam int unsigned CNT_PER_WORD = 16;
  localparam int unsigned SEL_W        = $clog2(CNT_PER_WORD);
  // Widest word address a 32-bit PC can yield once the low 6 bits are dropped
  localparam int unsigned ADDR_MAX_W   = 26;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2
  } upd_state_e;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic [SEL_W-1:0]      sel;
    logic                  taken;
  } upd_rec_t;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/dbp_upd_fifo.sv
// Synchronous FIFO of resolved-branch records; full/empty from wrap-bit pointers.
module dbp_upd_fifo
  import dbp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  upd_rec_t wdata,
  input  logic     pop,
  output upd_rec_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  upd_rec_t      mem_q [DEPTH];
  logic [PW:0]   wptr_q, rptr_q;
  logic          push_en, pop_en;

  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dbp_bht_updater.sv
// BHT channel-2 updater: queues resolved branches and applies each as a
// read-modify-write of one 2-bit saturating counter.
module dbp_bht_updater
  import dbp_pkg::*;
#(
  parameter int unsigned AWIDTH     = 10,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  output logic [AWIDTH-1:0] bht_add2,
  input  logic [DWIDTH-1:0] bht_rdata2,
  output logic              bht_wen2,
  output logic [DWIDTH-1:0] bht_wdata2,
  output logic              busy
);

  upd_state_e        state_q, state_d;
  upd_rec_t          head_q, head_d;
  logic [AWIDTH-1:0] add2_q, add2_d;
  upd_rec_t          push_rec, fifo_out;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [SEL_W:0]    fidx;

  always_comb begin
    push_rec             = '0;
    push_rec.addr[AWIDTH-1:0] = upd_pc[AWIDTH+5:6];
    push_rec.sel         = upd_pc[5:2];
    push_rec.taken       = upd_taken;
  end

  dbp_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (upd_valid),
    .wdata (push_rec),
    .pop   (fifo_pop),
    .rdata (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign upd_ready = !fifo_full;
  assign bht_add2  = add2_q;
  assign busy      = !fifo_empty || (state_q != StIdle);
  assign fidx      = {head_q.sel, 1'b0};

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    add2_d     = add2_q;
    fifo_pop   = 1'b0;
    bht_wen2   = 1'b0;
    bht_wdata2 = '0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          head_d   = fifo_out;
          add2_d   = fifo_out.addr[AWIDTH-1:0];
          state_d  = StRd;
        end
      end
      StRd: state_d = StWr;
      StWr: begin
        // Write is suppressed while reset is held so a reset in WR drops the update
        bht_wen2   = !reset;
        bht_wdata2 = bht_rdata2;
        bht_wdata2[fidx +: CNT_W] = sat_cnt(bht_rdata2[fidx +: CNT_W], head_q.taken);
        if (reset) bht_wdata2 = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          head_d   = fifo_out;
          add2_d   = fifo_out.addr[AWIDTH-1:0];
          state_d  = StRd;
        end else begin
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (reset) fifo_pop = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      head_q  <= '0;
      add2_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      add2_q  <= add2_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{upd_pc[31:AWIDTH+6], upd_pc[1:0], head_q.addr[ADDR_MAX_W-1:AWIDTH]};

endmodule
